// File: rtl/adder_result_stage_if.sv
// rtl/adder_result_stage_if.sv - handshake/data bundle between adder, result stage and its consumers
interface adder_result_stage_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
);
  logic                 Valid_i;
  logic                 Ready_o;
  logic [WIDTH-1:0]     Sum_i;
  logic                 C_i;
  logic                 Overflow_i;
  logic                 Sel_i;
  logic                 Sat_en_i;
  logic                 Valid_o;
  logic                 Ready_i;
  logic [WIDTH-1:0]     Result_o;
  logic [3:0]           Flags_o;
  logic                 Clr_sticky_i;
  logic                 Ovf_sticky_o;
  logic [CNT_WIDTH-1:0] Ovf_count_o;

  modport slave (
    input  Valid_i, Sum_i, C_i, Overflow_i, Sel_i, Sat_en_i, Ready_i, Clr_sticky_i,
    output Ready_o, Valid_o, Result_o, Flags_o, Ovf_sticky_o, Ovf_count_o
  );

  modport master (
    output Valid_i, Sum_i, C_i, Overflow_i, Sel_i, Sat_en_i, Ready_i, Clr_sticky_i,
    input  Ready_o, Valid_o, Result_o, Flags_o, Ovf_sticky_o, Ovf_count_o
  );
endinterface

// File: rtl/adder_result_stage.sv
// rtl/adder_result_stage.sv - 2-entry skid buffer capturing adder results with saturation, NZCV flags and overflow stats
module adder_result_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                Clk_i,
  input  logic                Rst_i,
  adder_result_stage_if.slave bus
);

  logic [1:0]           r_count;
  logic                 r_ready;
  logic                 r_valid;
  logic [WIDTH-1:0]     r_head_result;
  logic [3:0]           r_head_flags;
  logic [WIDTH-1:0]     r_skid_result;
  logic [3:0]           r_skid_flags;
  logic                 r_sticky;
  logic [CNT_WIDTH-1:0] r_ovf_cnt;

  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           w_next_count;
  logic [WIDTH-1:0]     w_result;
  logic                 w_flag_c;
  logic [3:0]           w_flags;

  always_comb begin
    w_push = bus.Valid_i & r_ready;
    w_pop  = r_valid & bus.Ready_i;

    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + 2'd1;
      2'b01:   w_next_count = r_count - 2'd1;
      default: w_next_count = r_count;
    endcase

    // Saturate toward the sign the true result would have had (opposite of Sum MSB).
    if (bus.Sat_en_i & bus.Overflow_i)
      w_result = {~bus.Sum_i[WIDTH-1], {(WIDTH-1){bus.Sum_i[WIDTH-1]}}};
    else
      w_result = bus.Sum_i;

    // Carry for add and no-borrow for subtract are both the raw adder carry.
    w_flag_c = bus.Sel_i ? bus.C_i : bus.C_i;
    w_flags  = {w_result[WIDTH-1], (w_result == '0), w_flag_c, bus.Overflow_i};
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_count       <= 2'd0;
      r_ready       <= 1'b1;
      r_valid       <= 1'b0;
      r_head_result <= '0;
      r_head_flags  <= 4'b0000;
      r_skid_result <= '0;
      r_skid_flags  <= 4'b0000;
    end else begin
      r_count <= w_next_count;
      r_ready <= (w_next_count != 2'd2);
      r_valid <= (w_next_count != 2'd0);
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_result <= w_result;
            r_head_flags  <= w_flags;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head_result <= w_result;
            r_head_flags  <= w_flags;
          end else if (w_push) begin
            r_skid_result <= w_result;
            r_skid_flags  <= w_flags;
          end
        end
        default: begin
          if (w_pop) begin
            r_head_result <= r_skid_result;
            r_head_flags  <= r_skid_flags;
          end
        end
      endcase
    end
  end

  // An overflow event in the same cycle as a clear wins and counts as the first event.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_sticky  <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_push && bus.Overflow_i) begin
      r_sticky <= 1'b1;
      if (bus.Clr_sticky_i)
        r_ovf_cnt <= CNT_WIDTH'(1);
      else if (r_ovf_cnt != {CNT_WIDTH{1'b1}})
        r_ovf_cnt <= r_ovf_cnt + CNT_WIDTH'(1);
    end else if (bus.Clr_sticky_i) begin
      r_sticky  <= 1'b0;
      r_ovf_cnt <= '0;
    end
  end

  assign bus.Ready_o      = r_ready;
  assign bus.Valid_o      = r_valid;
  assign bus.Result_o     = r_head_result;
  assign bus.Flags_o      = r_head_flags;
  assign bus.Ovf_sticky_o = r_sticky;
  assign bus.Ovf_count_o  = r_ovf_cnt;

endmodule
